// File: rtl/router_delay_link.sv
// ---------------------------------------------------------------------------
// router_delay_link
//
// Purpose:
//   Models one inter-FPGA router hop on a valid/ready link. Every accepted
//   word is stamped with a release time (now + ROUTER_DELAY) and kept in a
//   FIFO. The head word is presented downstream once its release time has
//   been reached. Order is strictly preserved, and backpressure works in both
//   directions.
//
// Ports:
//   clk            : single clock
//   reset          : synchronous, active-high; discards every stored word
//   in_data        : upstream word
//   in_valid       : upstream word valid
//   in_ready       : link can accept a word (not full, not in reset)
//   out_data       : head word, driven combinationally from the FIFO head
//   out_valid      : head word has reached its release time
//   out_ready      : downstream accepts the word
//   occupancy      : number of stored words, 0..FIFO_DEPTH
//   stat_msg_count : saturating count of accepted words (stats build only)
//   stat_peak_occ  : running maximum of occupancy (stats build only)
//
// Configuration:
//   Define ROUTER_LINK_STATS_EN to generate the statistics counters.
//   Without it both stat ports are tied to zero and no stats logic exists.
//   The datapath is identical either way.
// ---------------------------------------------------------------------------
module router_delay_link #(
    parameter int DATA_WIDTH   = 64,
    parameter int ROUTER_DELAY = 53,
    parameter int FIFO_DEPTH   = 64,
    parameter int TS_WIDTH     = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_WIDTH-1:0]         in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   occupancy,
    output logic [31:0]                   stat_msg_count,
    output logic [$clog2(FIFO_DEPTH):0]   stat_peak_occ
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int OW = AW + 1;
    localparam logic [TS_WIDTH-1:0] DELAY_TS  = TS_WIDTH'(ROUTER_DELAY);
    localparam logic [OW-1:0]       DEPTH_OCC = OW'(FIFO_DEPTH);

    // Free-running cycle counter; wraps naturally at 2**TS_WIDTH.
    logic [TS_WIDTH-1:0]   now_q, now_d;

    // FIFO storage: payload plus the cycle at which the word may leave.
    logic [DATA_WIDTH-1:0] dataMem [FIFO_DEPTH];
    logic [TS_WIDTH-1:0]   relMem  [FIFO_DEPTH];

    logic [AW-1:0]         wrPtr_q, wrPtr_d;
    logic [AW-1:0]         rdPtr_q, rdPtr_d;
    logic [OW-1:0]         occ_q, occ_d;

    logic                  full;
    logic                  due;
    logic                  push;
    logic                  pop;
    logic [TS_WIDTH-1:0]   headAge;

    // Handshake, eligibility and next-state logic.
    // The head is due when (now - release) is non-negative in the wrapped
    // sense, i.e. its MSB is clear. That only works because the delay is
    // kept below half the counter range. Full is taken from the registered
    // occupancy, so a pop never frees a slot for a push in the same cycle.
    always_comb begin
        full      = (occ_q == DEPTH_OCC);
        headAge   = now_q - relMem[rdPtr_q];
        due       = (occ_q != '0) && !headAge[TS_WIDTH-1];

        in_ready  = !reset && !full;
        out_valid = !reset && due;
        out_data  = dataMem[rdPtr_q];
        occupancy = occ_q;

        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;

        now_d     = now_q + TS_WIDTH'(1);
        wrPtr_d   = push ? wrPtr_q + AW'(1) : wrPtr_q;
        rdPtr_d   = pop  ? rdPtr_q + AW'(1) : rdPtr_q;

        occ_d     = occ_q;
        if (push && !pop) begin
            occ_d = occ_q + OW'(1);
        end else if (!push && pop) begin
            occ_d = occ_q - OW'(1);
        end
    end

    // Control state. A reset clears pointers and occupancy. Any words left in
    // the storage arrays become unreachable and can never be presented.
    always_ff @(posedge clk) begin
        if (reset) begin
            now_q   <= '0;
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            occ_q   <= '0;
        end else begin
            now_q   <= now_d;
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            occ_q   <= occ_d;
        end
    end

    // Storage write. There is no reset here because stale contents are
    // masked by the zero occupancy. The release stamp wraps with the counter.
    always_ff @(posedge clk) begin
        if (push) begin
            dataMem[wrPtr_q] <= in_data;
            relMem[wrPtr_q]  <= now_q + DELAY_TS;
        end
    end

`ifdef ROUTER_LINK_STATS_EN
    logic [31:0]   msgCount_q;
    logic [OW-1:0] peakOcc_q;

    // Accepted-word counter saturates instead of wrapping. The peak tracks
    // the next occupancy, so it always covers the value currently shown.
    always_ff @(posedge clk) begin
        if (reset) begin
            msgCount_q <= '0;
            peakOcc_q  <= '0;
        end else begin
            if (push && (msgCount_q != 32'hFFFF_FFFF)) begin
                msgCount_q <= msgCount_q + 32'd1;
            end
            if (occ_d > peakOcc_q) begin
                peakOcc_q <= occ_d;
            end
        end
    end

    assign stat_msg_count = msgCount_q;
    assign stat_peak_occ  = peakOcc_q;
`else
    assign stat_msg_count = '0;
    assign stat_peak_occ  = '0;
`endif

endmodule
